// File: rtl/serial_dispatch_pkg.sv
// serial_dispatch_pkg: shared crossbar helpers, round-robin first-free lane search
package serial_dispatch_pkg;
  localparam int MAX_LANES = 32;
  localparam int MAX_IDX_W = 5;
  function automatic logic [MAX_IDX_W:0] rr_first_free(
    input logic [MAX_LANES-1:0] mask,
    input int unsigned start,
    input int unsigned n
  );
    logic found;
    logic [MAX_IDX_W-1:0] sel;
    int unsigned idx;
    found = 1'b0;
    sel = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      idx = start + i;
      if (idx >= n) idx -= n;
      if (i < n && !found && mask[MAX_IDX_W'(idx)]) begin
        found = 1'b1;
        sel = MAX_IDX_W'(idx);
      end
    end
    return {found, sel};
  endfunction
endpackage

// File: rtl/serial_dispatch_rr_select.sv
// rr_select: combinational rotating priority pick of the first set mask bit from start
module rr_select
  import serial_dispatch_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0] mask_i,
  input  logic [LW-1:0]        start_i,
  output logic                 found_o,
  output logic [LW-1:0]        index_o
);
  logic [MAX_IDX_W:0] pick;
  assign pick = rr_first_free(MAX_LANES'(mask_i), 32'(start_i), NUM_LANES);
  assign found_o = pick[MAX_IDX_W];
  assign index_o = LW'(pick[MAX_IDX_W-1:0]);
endmodule

// File: rtl/serial_dispatch.sv
// serial_dispatch: stamps in-order beats with serials and spreads them round-robin over lanes under a credit limit
module serial_dispatch
  import serial_dispatch_pkg::*;
#(
  parameter type data_t = logic [31:0],
  parameter int NUM_LANES = 4,
  parameter int DEPTH = 64,
  parameter int SERIAL_WIDTH = $clog2(DEPTH),
  parameter bit LOCK_PACKET = 1'b0,
  parameter int KEEP_W = ($bits(data_t) + 7) / 8,
  parameter int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  data_t                   in_data_i,
  input  logic [KEEP_W-1:0]       in_keep_i,
  input  logic                    in_last_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output data_t                   out_data_o [NUM_LANES],
  output logic [KEEP_W-1:0]       out_keep_o [NUM_LANES],
  output logic [NUM_LANES-1:0]    out_last_o,
  output logic [SERIAL_WIDTH-1:0] out_tag_o [NUM_LANES],
  output logic [NUM_LANES-1:0]    out_valid_o,
  input  logic [NUM_LANES-1:0]    out_ready_i,
  input  logic                    credit_return_i,
  output logic [SERIAL_WIDTH:0]   in_flight_o,
  output logic                    err_underflow_o
);
  typedef enum logic {IDLE, LOCKED} lock_state_e;
  lock_state_e state_q;
  data_t data_q [NUM_LANES];
  logic [KEEP_W-1:0] keep_q [NUM_LANES];
  logic [SERIAL_WIDTH-1:0] tag_q [NUM_LANES];
  logic [NUM_LANES-1:0] last_q, valid_q, free, mask;
  logic [LW-1:0] lock_lane_q, rr_q, sel, rr_next;
  logic [SERIAL_WIDTH-1:0] serial_q;
  logic [SERIAL_WIDTH:0] in_flight_q, in_flight_d;
  logic err_q, found, accept, locked;
  always_comb begin
    free = ~valid_q | out_ready_i;
    locked = LOCK_PACKET && state_q == LOCKED;
    mask = locked ? free & (NUM_LANES'(1) << lock_lane_q) : free;
    in_ready_o = (in_flight_q < (SERIAL_WIDTH + 1)'(DEPTH)) && found;
    accept = in_valid_i && in_ready_o;
    rr_next = (sel == LW'(NUM_LANES - 1)) ? '0 : sel + 1'b1;
    in_flight_d = (accept && !credit_return_i) ? in_flight_q + 1'b1 :
                  (!accept && credit_return_i && in_flight_q != '0) ? in_flight_q - 1'b1 :
                  in_flight_q;
  end
  // while locked the mask is one-hot, so the start pointer is irrelevant
  rr_select #(.NUM_LANES(NUM_LANES), .LW(LW)) u_rr (
    .mask_i (mask),
    .start_i(rr_q),
    .found_o(found),
    .index_o(sel)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= '0;
      serial_q    <= '0;
      in_flight_q <= '0;
      rr_q        <= '0;
      state_q     <= IDLE;
      lock_lane_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (accept && sel == LW'(i)) begin
          data_q[i]  <= in_data_i;
          keep_q[i]  <= in_keep_i;
          last_q[i]  <= in_last_i;
          tag_q[i]   <= serial_q;
          valid_q[i] <= 1'b1;
        end else if (out_ready_i[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (accept) serial_q <= serial_q + 1'b1;
      // in lock mode the pointer only moves once a packet closes
      if (accept && (!LOCK_PACKET || in_last_i)) rr_q <= rr_next;
      if (LOCK_PACKET && accept) begin
        if (state_q == IDLE && !in_last_i) begin
          state_q     <= LOCKED;
          lock_lane_q <= sel;
        end else if (state_q == LOCKED && in_last_i) begin
          state_q <= IDLE;
        end
      end
      in_flight_q <= in_flight_d;
      err_q       <= err_q | (credit_return_i && in_flight_q == '0);
    end
  end
  assign out_data_o      = data_q;
  assign out_keep_o      = keep_q;
  assign out_tag_o       = tag_q;
  assign out_last_o      = last_q;
  assign out_valid_o     = valid_q;
  assign in_flight_o     = in_flight_q;
  assign err_underflow_o = err_q;
endmodule
